// File: rtl/sdram_burst_reader_if.sv
// rtl/sdram_burst_reader_if.sv - Avalon-MM burst read bus between the reader and the SDRAM controller
interface sdram_burst_reader_if #(
  parameter int ADDR_WIDTH        = 32,
  parameter int DATA_WIDTH        = 64,
  parameter int BURST_COUNT_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0]        avm_address;
  logic [BURST_COUNT_WIDTH-1:0] avm_burst_count;
  logic                         avm_read;
  logic                         avm_write;
  logic [DATA_WIDTH-1:0]        avm_write_data;
  logic [DATA_WIDTH/8-1:0]      avm_byte_enable;
  logic                         avm_wait_request;
  logic [DATA_WIDTH-1:0]        avm_read_data;
  logic                         avm_readdata_val;

  modport master (
    output avm_address, avm_burst_count, avm_read, avm_write, avm_write_data, avm_byte_enable,
    input  avm_wait_request, avm_read_data, avm_readdata_val
  );

  modport slave (
    input  avm_address, avm_burst_count, avm_read, avm_write, avm_write_data, avm_byte_enable,
    output avm_wait_request, avm_read_data, avm_readdata_val
  );
endinterface

// File: rtl/sdram_burst_reader.sv
// rtl/sdram_burst_reader.sv - Avalon-MM burst read master with credit-limited FIFO and sop/eop stream
module sdram_burst_reader #(
  parameter int ADDR_WIDTH        = 32,
  parameter int DATA_WIDTH        = 64,
  parameter int BURST_COUNT_WIDTH = 8,
  parameter int MAX_BURST         = 16,
  parameter int FIFO_DEPTH        = 64,
  parameter int LEN_WIDTH         = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  busy,
  output logic                  done,
  sdram_burst_reader_if.master  avm,
  output logic [DATA_WIDTH-1:0] src_data,
  output logic                  src_valid,
  input  logic                  src_ready,
  output logic                  src_sop,
  output logic                  src_eop
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int OW    = PW + 1;
  localparam int CW    = PW + 2;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]  remaining, len_reg, word_cnt, burst_len;
  logic [OW-1:0]         fifo_count, outstanding;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [CW-1:0]         credit;
  logic                  read_req, accept, cmd_take, done_r, done_next;
  logic                  beat_wr, fifo_rd, pop;

  // Burst sizing and credit: never request more words than the FIFO can absorb.
  always_comb begin
    burst_len = (remaining > LEN_WIDTH'(MAX_BURST)) ? LEN_WIDTH'(MAX_BURST) : remaining;
    credit    = CW'(FIFO_DEPTH) - CW'(fifo_count) - CW'(outstanding);
    beat_wr   = avm.avm_readdata_val && (outstanding != '0);
    pop       = src_valid && src_ready;
    fifo_rd   = (fifo_count != '0) && (!src_valid || src_ready);
  end

  // FSM next-state and command/bus handshake decode.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    read_req   = 1'b0;
    accept     = 1'b0;
    cmd_take   = 1'b0;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = !rst;
        if (cmd_valid && !rst) begin
          if (cmd_len != '0) begin
            cmd_take   = 1'b1;
            state_next = ISSUE;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      ISSUE: begin
        read_req = !rst && (credit >= CW'(burst_len));
        accept   = read_req && !avm.avm_wait_request;
        if (accept && (remaining == burst_len)) state_next = DRAIN;
      end
      DRAIN: begin
        if (pop && src_eop) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Command address/length tracking and the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      remaining <= '0;
      len_reg   <= '0;
      done_r    <= 1'b0;
    end else begin
      done_r <= done_next;
      if (cmd_take) begin
        addr      <= cmd_addr;
        remaining <= cmd_len;
        len_reg   <= cmd_len;
      end else if (accept) begin
        addr      <= addr + (ADDR_WIDTH'(burst_len) << $clog2(BYTES));
        remaining <= remaining - burst_len;
      end
    end
  end

  // Words requested but not yet returned; stale beats with nothing outstanding are dropped.
  always_ff @(posedge clk) begin
    if (rst) outstanding <= '0;
    else     outstanding <= outstanding + (accept ? OW'(burst_len) : OW'(0)) - (beat_wr ? OW'(1) : OW'(0));
  end

  // FIFO storage; no reset needed since occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (beat_wr) mem[wr_ptr] <= avm.avm_read_data;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (beat_wr) wr_ptr <= wr_ptr + PW'(1);
      if (fifo_rd) rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= fifo_count + (beat_wr ? OW'(1) : OW'(0)) - (fifo_rd ? OW'(1) : OW'(0));
    end
  end

  // Registered stream output stage with sop/eop derived from the word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_valid <= 1'b0;
      src_data  <= '0;
      src_sop   <= 1'b0;
      src_eop   <= 1'b0;
      word_cnt  <= '0;
    end else begin
      if (cmd_take) word_cnt <= '0;
      if (fifo_rd) begin
        src_valid <= 1'b1;
        src_data  <= mem[rd_ptr];
        src_sop   <= (word_cnt == '0);
        src_eop   <= (word_cnt == len_reg - LEN_WIDTH'(1));
        word_cnt  <= word_cnt + LEN_WIDTH'(1);
      end else if (src_ready) begin
        src_valid <= 1'b0;
        src_sop   <= 1'b0;
        src_eop   <= 1'b0;
      end
    end
  end

  // The credit rule must keep the FIFO from ever being written while full.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(beat_wr && !fifo_rd && (fifo_count == OW'(FIFO_DEPTH))));
  end

  assign busy                = (state != IDLE);
  assign done                = done_r;
  assign avm.avm_address     = addr;
  assign avm.avm_burst_count = BURST_COUNT_WIDTH'(burst_len);
  assign avm.avm_read        = read_req;
  assign avm.avm_write       = 1'b0;
  assign avm.avm_write_data  = '0;
  assign avm.avm_byte_enable = '1;
endmodule

// File: tb/tb_sdram_burst_reader.sv
// tb/tb_sdram_burst_reader.sv - directed self-checking bench for sdram_burst_reader
module tb_sdram_burst_reader;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr;
  logic [23:0] cmd_len;
  logic        busy, done;
  logic [63:0] src_data;
  logic        src_valid, src_ready, src_sop, src_eop;

  sdram_burst_reader_if bus ();

  sdram_burst_reader dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .busy(busy), .done(done), .avm(bus.master),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .src_sop(src_sop), .src_eop(src_eop)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] word_of(input logic [31:0] a);
    return {a ^ 32'hDEAD_BEEF, a};
  endfunction

  // slave model / sink state
  logic [31:0] pend[$];
  logic [31:0] burst_addr[$];
  int          burst_cnt[$];
  logic [63:0] rx_data[$];
  logic        rx_sop[$], rx_eop[$];
  int  cyc = 0, done_cnt, issued, popped, eop_cycle, done_cycle;
  int  stall_left = 0, stall_target = -1, stall_samples, stall_bad, both_bad = 0;
  logic [31:0] stall_addr;
  int  stall_cnt_exp;
  logic sink_ready = 1'b1, inject_stale = 1'b0, busy_seen, stalled_prev = 1'b0;

  task automatic clear_logs();
    pend.delete(); burst_addr.delete(); burst_cnt.delete();
    rx_data.delete(); rx_sop.delete(); rx_eop.delete();
    done_cnt = 0; issued = 0; popped = 0; eop_cycle = -1; done_cycle = -2;
    stall_samples = 0; stall_bad = 0; busy_seen = 1'b0;
  endtask

  // SDRAM slave model and stream sink: drive at negedge, observe 1ns later.
  initial begin
    bus.avm_wait_request = 1'b0;
    bus.avm_read_data    = '0;
    bus.avm_readdata_val = 1'b0;
    src_ready            = 1'b0;
    clear_logs();
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) pend.delete();
      src_ready = sink_ready;
      bus.avm_wait_request = (stall_left > 0) && (burst_addr.size() == stall_target);
      if (inject_stale) begin
        bus.avm_readdata_val = 1'b1;
        bus.avm_read_data    = 64'h0BAD_0BAD_0BAD_0BAD;
        inject_stale         = 1'b0;
      end else if (!rst && pend.size() > 0) begin
        bus.avm_readdata_val = 1'b1;
        bus.avm_read_data    = word_of(pend.pop_front());
      end else begin
        bus.avm_readdata_val = 1'b0;
      end
      #1;
      if (stalled_prev && !bus.avm_read && !rst) stall_bad++;
      stalled_prev = bus.avm_read && bus.avm_wait_request;
      if (bus.avm_read && bus.avm_wait_request) begin
        stall_samples++;
        stall_left--;
        if (bus.avm_address !== stall_addr || int'(bus.avm_burst_count) != stall_cnt_exp) stall_bad++;
      end
      if (bus.avm_read && !bus.avm_wait_request && !rst) begin
        burst_addr.push_back(bus.avm_address);
        burst_cnt.push_back(int'(bus.avm_burst_count));
        for (int i = 0; i < int'(bus.avm_burst_count); i++)
          pend.push_back(bus.avm_address + 32'(i * 8));
        issued += int'(bus.avm_burst_count);
      end
      if (src_valid && src_ready && !rst) begin
        rx_data.push_back(src_data);
        rx_sop.push_back(src_sop);
        rx_eop.push_back(src_eop);
        popped++;
        if (src_eop) eop_cycle = cyc;
      end
      if (done) begin done_cnt++; done_cycle = cyc; end
      if (done && busy) both_bad++;
      if (busy) busy_seen = 1'b1;
    end
  end

  task automatic send_cmd(input logic [31:0] a, input logic [23:0] l);
    int k = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l;
    #2;
    while (!cmd_ready && k < 100) begin @(negedge clk); #2; k++; end
    if (k >= 100) check("cmd_accept_timeout", 1, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (done_cnt < 1 && k < budget) begin @(negedge clk); #2; k++; end
    check({tag, "_done_seen"}, done_cnt >= 1, 1);
    repeat (5) @(negedge clk);
    #2;
    check({tag, "_done_once"}, done_cnt, 1);
  endtask

  task automatic check_stream(input string tag, input logic [31:0] base, input int len);
    int errs = 0;
    for (int i = 0; i < rx_data.size(); i++) begin
      if (rx_data[i] !== word_of(base + 32'(i * 8))) errs++;
      if (rx_sop[i] !== (i == 0)) errs++;
      if (rx_eop[i] !== (i == len - 1)) errs++;
    end
    check({tag, "_words"}, rx_data.size(), len);
    check({tag, "_word_err"}, errs, 0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_avm_read", bus.avm_read, 0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_outs", {busy, done, src_valid, src_sop, src_eop}, 5'b0);
    check("post_rst_addr", bus.avm_address, 0);
    check("post_rst_bcount", bus.avm_burst_count, 0);
    check("const_write", {bus.avm_write, bus.avm_byte_enable}, 9'h0FF);
    check("const_wdata", bus.avm_write_data, 0);

    // single word
    clear_logs();
    send_cmd(32'h1000, 24'd1);
    wait_done("t1", 200);
    check("t1_bursts", burst_addr.size(), 1);
    check("t1_b0_addr", burst_addr[0], 32'h1000);
    check("t1_b0_cnt", burst_cnt[0], 1);
    check_stream("t1", 32'h1000, 1);
    check("t1_sop_eop", {rx_sop[0], rx_eop[0]}, 2'b11);
    check("t1_done_lat", done_cycle, eop_cycle + 1);

    // 40 words split into 16/16/8
    clear_logs();
    send_cmd(32'h1000, 24'd40);
    wait_done("t2", 500);
    check("t2_bursts", burst_addr.size(), 3);
    check("t2_b0", {burst_addr[0], 32'(burst_cnt[0])}, {32'h1000, 32'd16});
    check("t2_b1", {burst_addr[1], 32'(burst_cnt[1])}, {32'h1080, 32'd16});
    check("t2_b2", {burst_addr[2], 32'(burst_cnt[2])}, {32'h1100, 32'd8});
    check_stream("t2", 32'h1000, 40);

    // 5-cycle wait_request on the second burst
    clear_logs();
    stall_addr = 32'h1080; stall_cnt_exp = 16; stall_target = 1; stall_left = 5;
    send_cmd(32'h1000, 24'd40);
    wait_done("t3", 500);
    check("t3_stall_cycles", stall_samples, 5);
    check("t3_stall_stable", stall_bad, 0);
    check("t3_bursts", burst_addr.size(), 3);
    check("t3_b1", {burst_addr[1], 32'(burst_cnt[1])}, {32'h1080, 32'd16});
    check_stream("t3", 32'h1000, 40);
    stall_target = -1;

    // backpressure: credit limits in-flight words to the FIFO depth
    clear_logs();
    sink_ready = 1'b0;
    send_cmd(32'h4000, 24'd200);
    repeat (300) @(negedge clk);
    #2;
    check("t4_issued_capped", issued, 64);
    check("t4_read_idle", bus.avm_read, 0);
    check("t4_no_pop", rx_data.size(), 0);
    sink_ready = 1'b1;
    wait_done("t4", 2000);
    check("t4_bursts", burst_addr.size(), 13);
    check("t4_last", {burst_addr[12], 32'(burst_cnt[12])}, {32'h4600, 32'd8});
    check_stream("t4", 32'h4000, 200);

    // zero-length command
    clear_logs();
    send_cmd(32'h1000, 24'd0);
    repeat (5) @(negedge clk);
    #2;
    check("t5_done", done_cnt, 1);
    check("t5_no_bursts", burst_addr.size(), 0);
    check("t5_busy", busy_seen, 0);

    // reset during the second burst
    clear_logs();
    stall_addr = 32'h1080; stall_cnt_exp = 16; stall_target = 1; stall_left = 20;
    send_cmd(32'h1000, 24'd40);
    begin
      int k = 0;
      while (stall_samples < 2 && k < 200) begin @(negedge clk); #2; k++; end
      check("t6_reach_stall", stall_samples >= 2, 1);
    end
    @(negedge clk);
    rst = 1'b1;
    #2;
    check("t6_read_drop", bus.avm_read, 0);
    check("t6_cmd_ready_rst", cmd_ready, 0);
    @(negedge clk);
    #2;
    check("t6_rst_outs", {bus.avm_read, busy, done, src_valid, src_sop, src_eop}, 6'b0);
    check("t6_rst_bus", {bus.avm_address, 24'(bus.avm_burst_count)}, 56'h0);
    @(negedge clk);
    rst = 1'b0; stall_left = 0; stall_target = -1;
    clear_logs();
    inject_stale = 1'b1;
    repeat (3) @(negedge clk);
    send_cmd(32'h2000, 24'd2);
    wait_done("t6", 200);
    check("t6_bursts", burst_addr.size(), 1);
    check("t6_b0", {burst_addr[0], 32'(burst_cnt[0])}, {32'h2000, 32'd2});
    check_stream("t6", 32'h2000, 2);

    check("done_busy_overlap", both_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sdram_burst_reader.md
Name: sdram_burst_reader

Overview:
- Avalon-MM burst read master that drives the master side of the SDRAM Avalon-MM interface.
- Takes a read command (start byte address, length in words) and splits it into bursts of at most MAX_BURST words.
- Buffers the returned read data in an internal FIFO and presents it as a valid/ready stream with start/end markers.
- Sits directly upstream of the SDRAM controller slave port; feeds the DMA/packet-TX path.

Parameters:
- ADDR_WIDTH, 32, Avalon byte address width.
- DATA_WIDTH, 64, data word width; BYTES = DATA_WIDTH/8.
- BURST_COUNT_WIDTH, 8, burst count width; must satisfy MAX_BURST < 2**BURST_COUNT_WIDTH.
- MAX_BURST, 16, maximum words per burst.
- FIFO_DEPTH, 64, read buffer depth in words; power of two, >= MAX_BURST.
- LEN_WIDTH, 24, command length width in words.

Ports:
- clk  in  1  single clock for all logic and the Avalon bus.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_addr  in  ADDR_WIDTH  start byte address; BYTES-aligned.
- cmd_len  in  LEN_WIDTH  length in words.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse at command completion.
- avm_address  out  ADDR_WIDTH  burst start byte address.
- avm_burst_count  out  BURST_COUNT_WIDTH  words in this burst.
- avm_read  out  1  read request.
- avm_write  out  1  constant 0.
- avm_write_data  out  DATA_WIDTH  constant 0.
- avm_byte_enable  out  DATA_WIDTH/8  constant all ones.
- avm_wait_request  in  1  slave stall.
- avm_read_data  in  DATA_WIDTH  returned data.
- avm_readdata_val  in  1  returned data valid.
- src_data  out  DATA_WIDTH  stream data.
- src_valid  out  1  stream valid.
- src_ready  in  1  stream ready.
- src_sop  out  1  first word of command.
- src_eop  out  1  last word of command.

Behaviour:
- Reset values:
  - cmd_ready=0 during rst, 1 on the first cycle after rst is released.
  - avm_read=0, avm_address=0, avm_burst_count=0.
  - busy=0, done=0, src_valid=0, src_sop=0, src_eop=0.
  - FIFO empty; outstanding=0; all counters 0.
- FSM:
  - IDLE: cmd_ready=1.
    - cmd_valid with cmd_len!=0 -> latch addr/len, go to ISSUE.
    - cmd_valid with cmd_len==0 -> done pulses next cycle, stay in IDLE, no bus activity.
  - ISSUE: burst = min(MAX_BURST, words remaining to issue).
    - Assert avm_read only when credit >= burst, where credit = FIFO_DEPTH - fifo_used - outstanding.
    - Request accepted on avm_read & !avm_wait_request.
    - On accept: address += burst*BYTES; remaining -= burst; outstanding += burst.
    - After the accept of the last burst, deassert avm_read and go to DRAIN.
  - DRAIN: wait until the eop word is popped (src_valid&src_ready&src_eop). Then go to IDLE with done=1 for one cycle.
- Latency and bus timing:
  - The first avm_read is asserted the cycle after command accept if credit allows.
  - While avm_wait_request=1, avm_address, avm_burst_count and avm_read are held stable.
  - Back-to-back bursts are allowed: a new request may follow in the cycle after an accept.
- Read data path:
  - Every avm_readdata_val beat writes the FIFO and decrements outstanding; no backpressure to the slave.
  - The credit rule guarantees the FIFO never overflows. Overflow is an assertion failure.
  - A readdata_val beat while outstanding==0 is dropped, so stale beats after reset are discarded.
  - Simultaneous accept and readdata_val: outstanding += burst - 1.
- Stream output:
  - src_valid is asserted one cycle after the first data beat is written.
  - The FIFO is registered; src_data/sop/eop are held while src_valid&!src_ready.
  - src_sop marks word 0 of the command; src_eop marks word cmd_len-1. Both are set on the same word when len==1.
  - A word counter (LEN_WIDTH) tracks popped words.
- busy=1 from the cycle after accept until the cycle done is asserted. done and busy are never 1 together.
- Address wrap: avm_address wraps modulo 2**ADDR_WIDTH with no error.
- rst mid-operation: FSM returns to IDLE, the FIFO and outstanding are cleared, and avm_read drops immediately. The SDRAM controller is reset together with this block.

Test Plan:
- cmd_addr=0x1000, cmd_len=1, no stalls, src_ready=1 -> one burst: address 0x1000, burst_count 1; one word out with sop=eop=1; done one cycle after the pop.
- cmd_addr=0x1000, cmd_len=40 -> bursts (0x1000,16), (0x1080,16), (0x1100,8); 40 words out in order with sop on word 0 and eop on word 39; exactly one done pulse.
- avm_wait_request held high for 5 cycles on the second burst -> address 0x1080 and count 16 stable all 5 cycles; data order intact.
- src_ready=0, cmd_len=200 -> after 64 words are outstanding or buffered, no further avm_read. Releasing src_ready resumes bursts; all 200 words delivered and the FIFO never overflows.
- cmd_len=0 -> no avm_read; done pulses once; busy stays 0.
- rst asserted during the second burst of len=40 -> next cycle all outputs at reset values. A new command (0x2000, 2) afterwards produces exactly 2 correct words.
